// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - holds one 4-lane fetch group, feeds decoders, drains into the issue queue
// Optional feature macro: DECODE_STALL_CNT_EN (adds the stall_cycles counter and port).
module decode_issue_ctrl #(
   parameter int LANES = 4,
   parameter int CNT_W = 3,
   parameter int REQ_W = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          in_valid,
   input  logic [CNT_W-1:0]              in_count,
   input  logic [LANES-1:0][REQ_W-1:0]   in_req,
   output logic                          in_ready,
   input  logic [CNT_W-1:0]              iq_size_left,
   output logic [LANES-1:0][REQ_W-1:0]   dec_req,
   output logic [CNT_W-1:0]              iq_push_num,
   output logic                          busy
`ifdef DECODE_STALL_CNT_EN
   ,
   output logic [31:0]                   stall_cycles
`endif
);

   localparam logic [CNT_W-1:0] MAX_LANES = CNT_W'(LANES);

   logic [LANES-1:0][REQ_W-1:0] lane_q, lane_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [CNT_W-1:0]            room, ld, push;
   logic                        hold, accept;

   // EMPTY and HOLD are fully encoded by cnt_q, so the state register is the lane count
   assign hold   = (cnt_q != '0);
   assign room   = (iq_size_left > MAX_LANES) ? MAX_LANES : iq_size_left;
   assign ld     = (in_count > MAX_LANES) ? MAX_LANES : in_count;
   assign push   = (cnt_q < room) ? cnt_q : room;
   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         lane_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         lane_q <= lane_d;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      lane_d = lane_q;
      if (flush) begin
         cnt_d = '0;
      end else if (accept) begin
         lane_d = in_req;
         cnt_d  = ld;
      end else if (hold) begin
         // compact survivors down to lane 0; vacated upper lanes keep their old contents
         for (int i = 0; i < LANES; i++) begin
            if ((i + int'(push)) < LANES)
               lane_d[i] = lane_q[2'(i) + push[1:0]];
         end
         cnt_d = cnt_q - push;
      end
   end

   always_comb begin
      busy        = hold;
      iq_push_num = push;
      dec_req     = lane_q;
      // combinational through iq_size_left so a new group loads as the last lanes drain
      in_ready    = rst_n && !flush && (!hold || (push == cnt_q));
   end

`ifdef DECODE_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_q <= '0;
      else if (hold && (room == '0) && !flush && (stall_q != 32'hFFFF_FFFF))
         stall_q <= stall_q + 32'd1;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb/tb_decode_issue_ctrl.sv - directed self-checking bench for decode_issue_ctrl
module tb_decode_issue_ctrl;

   localparam int CNT_W = 3;
   localparam int REQ_W = 16;

   logic                clk = 1'b0;
   logic                rst_n, flush, in_valid, in_ready, busy;
   logic [CNT_W-1:0]    in_count, iq_size_left, iq_push_num;
   logic [3:0][REQ_W-1:0] in_req, dec_req;
`ifdef DECODE_STALL_CNT_EN
   logic [31:0]         stall_cycles;
`endif

   int n_pass  = 0;
   int n_total = 0;

   decode_issue_ctrl #(.LANES(4), .CNT_W(CNT_W), .REQ_W(REQ_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_count     (in_count),
      .in_req       (in_req),
      .in_ready     (in_ready),
      .iq_size_left (iq_size_left),
      .dec_req      (dec_req),
      .iq_push_num  (iq_push_num),
      .busy         (busy)
`ifdef DECODE_STALL_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [3:0][REQ_W-1:0] grp(input logic [7:0] tag);
      for (int i = 0; i < 4; i++) grp[i] = {tag, 8'(i)};
   endfunction

   // inputs change on the falling edge; outputs are sampled 1 time unit later
   task automatic cyc(input logic v, input logic [CNT_W-1:0] c, input logic [7:0] tag,
                      input logic [CNT_W-1:0] room, input logic fl);
      @(negedge clk);
      in_valid = v; in_count = c; in_req = grp(tag); iq_size_left = room; flush = fl;
      #1;
   endtask

   task automatic test_reset;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         rst_n = 1'b0; in_valid = 1'b1; in_count = 3'd4; iq_size_left = 3'd4; flush = 1'b0;
         #1;
         n_total++;
         if (in_ready !== 1'b0) $display("FAIL reset_in_ready cyc%0d: got %b want 0", k, in_ready);
         else n_pass++;
      end
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0; iq_size_left = 3'd4;
      #1;
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++;
      if (iq_push_num !== 3'd0) $display("FAIL reset_push: got %0d want 0", iq_push_num); else n_pass++;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", in_ready); else n_pass++;
`ifdef DECODE_STALL_CNT_EN
      n_total++;
      if (stall_cycles !== 32'd0) $display("FAIL reset_stall: got %0d want 0", stall_cycles); else n_pass++;
`endif
   endtask

   task automatic test_streaming;
      logic [3:0][REQ_W-1:0] exp;
      for (int k = 0; k < 5; k++) begin
         cyc(k < 4, 3'd4, 8'(8'h10 + k), 3'd4, 1'b0);
         n_total++;
         if (in_ready !== 1'b1) $display("FAIL stream_ready c%0d: got %b want 1", k, in_ready); else n_pass++;
         if (k >= 1) begin
            exp = grp(8'(8'h10 + k - 1));
            n_total++;
            if (iq_push_num !== 3'd4) $display("FAIL stream_push c%0d: got %0d want 4", k, iq_push_num);
            else n_pass++;
            n_total++;
            if (dec_req !== exp) $display("FAIL stream_lanes c%0d: got %h want %h", k, dec_req, exp);
            else n_pass++;
         end
      end
      cyc(1'b0, 3'd0, 8'h00, 3'd4, 1'b0);
      n_total++;
      if (busy !== 1'b0 || iq_push_num !== 3'd0)
         $display("FAIL stream_idle: got busy=%b push=%0d want busy=0 push=0", busy, iq_push_num);
      else n_pass++;
   endtask

   task automatic test_partial;
      cyc(1'b1, 3'd4, 8'hA0, 3'd4, 1'b0);               // load A..D
      cyc(1'b1, 3'd4, 8'hE0, 3'd1, 1'b0);
      n_total++;
      if (iq_push_num !== 3'd1 || dec_req[0] !== 16'hA000 || in_ready !== 1'b0)
         $display("FAIL partial_1: got push=%0d l0=%h rdy=%b want push=1 l0=a000 rdy=0", iq_push_num, dec_req[0], in_ready);
      else n_pass++;
      cyc(1'b1, 3'd4, 8'hE0, 3'd2, 1'b0);
      n_total++;
      if (iq_push_num !== 3'd2 || dec_req[0] !== 16'hA001 || dec_req[1] !== 16'hA002 || in_ready !== 1'b0)
         $display("FAIL partial_2: got push=%0d l0=%h l1=%h rdy=%b want push=2 l0=a001 l1=a002 rdy=0",
                  iq_push_num, dec_req[0], dec_req[1], in_ready);
      else n_pass++;
      cyc(1'b1, 3'd4, 8'hE0, 3'd4, 1'b0);               // last lane drains, group E loads
      n_total++;
      if (iq_push_num !== 3'd1 || dec_req[0] !== 16'hA003 || in_ready !== 1'b1)
         $display("FAIL partial_3: got push=%0d l0=%h rdy=%b want push=1 l0=a003 rdy=1", iq_push_num, dec_req[0], in_ready);
      else n_pass++;
      cyc(1'b0, 3'd0, 8'h00, 3'd1, 1'b0);
      n_total++;
      if (iq_push_num !== 3'd1 || dec_req[0] !== 16'hE000 || busy !== 1'b1)
         $display("FAIL partial_next: got push=%0d l0=%h busy=%b want push=1 l0=e000 busy=1", iq_push_num, dec_req[0], busy);
      else n_pass++;
   endtask

   task automatic test_full_queue;
      // entered in HOLD with cnt=3 holding E1,E2,E3
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 3'd4, 8'hF0, 3'd0, 1'b0);
         n_total++;
         if (iq_push_num !== 3'd0 || in_ready !== 1'b0 || busy !== 1'b1 || dec_req[0] !== 16'hE001)
            $display("FAIL full_hold c%0d: got push=%0d rdy=%b busy=%b l0=%h want 0/0/1/e001",
                     k, iq_push_num, in_ready, busy, dec_req[0]);
         else n_pass++;
      end
      cyc(1'b0, 3'd0, 8'h00, 3'd4, 1'b0);
      n_total++;
      if (iq_push_num !== 3'd3 || dec_req[0] !== 16'hE001 || dec_req[1] !== 16'hE002 ||
          dec_req[2] !== 16'hE003 || in_ready !== 1'b1)
         $display("FAIL full_release: got push=%0d l=%h rdy=%b want push=3 e001,e002,e003 rdy=1",
                  iq_push_num, dec_req, in_ready);
      else n_pass++;
`ifdef DECODE_STALL_CNT_EN
      n_total++;
      if (stall_cycles !== 32'd5) $display("FAIL full_stall_cnt: got %0d want 5", stall_cycles); else n_pass++;
`endif
   endtask

   task automatic test_flush;
      cyc(1'b1, 3'd4, 8'hB0, 3'd2, 1'b0);
      cyc(1'b0, 3'd0, 8'h00, 3'd2, 1'b0);
      n_total++;
      if (iq_push_num !== 3'd2) $display("FAIL flush_pre_push: got %0d want 2", iq_push_num); else n_pass++;
      cyc(1'b1, 3'd4, 8'hC0, 3'd0, 1'b1);               // flush with a group offered
      n_total++;
      if (in_ready !== 1'b0 || iq_push_num !== 3'd0)
         $display("FAIL flush_cycle: got rdy=%b push=%0d want rdy=0 push=0", in_ready, iq_push_num);
      else n_pass++;
      cyc(1'b0, 3'd0, 8'h00, 3'd4, 1'b0);
      n_total++;
      if (busy !== 1'b0 || iq_push_num !== 3'd0 || in_ready !== 1'b1)
         $display("FAIL flush_after: got busy=%b push=%0d rdy=%b want 0/0/1", busy, iq_push_num, in_ready);
      else n_pass++;
`ifdef DECODE_STALL_CNT_EN
      n_total++;
      if (stall_cycles !== 32'd5) $display("FAIL flush_stall_kept: got %0d want 5", stall_cycles); else n_pass++;
`endif
   endtask

   task automatic test_clamping;
      cyc(1'b1, 3'd7, 8'hD0, 3'd6, 1'b0);
      n_total++;
      if (in_ready !== 1'b1 || iq_push_num !== 3'd0)
         $display("FAIL clamp_load: got rdy=%b push=%0d want rdy=1 push=0", in_ready, iq_push_num);
      else n_pass++;
      cyc(1'b0, 3'd0, 8'h00, 3'd6, 1'b0);
      n_total++;
      if (iq_push_num !== 3'd4 || busy !== 1'b1 || dec_req !== grp(8'hD0))
         $display("FAIL clamp_push: got push=%0d busy=%b lanes=%h want push=4 busy=1", iq_push_num, busy, dec_req);
      else n_pass++;
      cyc(1'b1, 3'd0, 8'h90, 3'd4, 1'b0);                // empty group offered
      n_total++;
      if (busy !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL clamp_empty_offer: got busy=%b rdy=%b want 0/1", busy, in_ready);
      else n_pass++;
      cyc(1'b0, 3'd0, 8'h00, 3'd4, 1'b0);
      n_total++;
      if (busy !== 1'b0 || iq_push_num !== 3'd0)
         $display("FAIL clamp_zero_count: got busy=%b push=%0d want 0/0", busy, iq_push_num);
      else n_pass++;
   endtask

   task automatic test_reset_in_hold;
      cyc(1'b1, 3'd3, 8'h70, 3'd0, 1'b0);
      cyc(1'b0, 3'd0, 8'h00, 3'd0, 1'b0);
      n_total++;
      if (busy !== 1'b1) $display("FAIL rih_loaded: got busy=%b want 1", busy); else n_pass++;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL rih_ready: got %b want 0", in_ready); else n_pass++;
      cyc(1'b0, 3'd0, 8'h00, 3'd4, 1'b0);
      rst_n = 1'b1;
      #1;
      n_total++;
      if (busy !== 1'b0 || iq_push_num !== 3'd0 || in_ready !== 1'b1)
         $display("FAIL rih_after: got busy=%b push=%0d rdy=%b want 0/0/1", busy, iq_push_num, in_ready);
      else n_pass++;
`ifdef DECODE_STALL_CNT_EN
      n_total++;
      if (stall_cycles !== 32'd0) $display("FAIL rih_stall_clear: got %0d want 0", stall_cycles); else n_pass++;
`endif
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_count = '0; in_req = '0; iq_size_left = '0;
      test_reset();
      test_streaming();
      test_partial();
      test_full_queue();
      test_flush();
      test_clamping();
      test_reset_in_hold();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
